// File: rtl/demux16_dispatch_pkg.sv
// Shared constants for the 16-way dispatch demux and its companion lib muxes.
package demux16_dispatch_pkg;
  localparam int NLANES = 16;
  localparam int SELW   = 4;
endpackage

// File: rtl/demux_lane.sv
// One output lane: a single registered entry that loads on dispatch and drains on out_ready.
module demux_lane #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] in_data,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data
);
  logic         valid_d, valid_q;
  logic [W-1:0] data_d, data_q;

  // A load in the same cycle as a drain keeps the lane full with the new word.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (valid_q && out_ready) valid_d = 1'b0;
    if (load) begin
      valid_d = 1'b1;
      data_d  = in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
endmodule

// File: rtl/demux16_dispatch.sv
// Routes one input word per cycle to one of 16 single-entry output lanes, selected by in_sel.
module demux16_dispatch
  import demux16_dispatch_pkg::*;
#(
  parameter int W = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SELW-1:0]     in_sel,
  input  logic [W-1:0]        in_data,
  output logic [NLANES-1:0]   out_valid,
  input  logic [NLANES-1:0]   out_ready,
  output logic [NLANES*W-1:0] out_data,
  output logic                busy
);
  logic [NLANES-1:0] load;

  // Ready only looks at the addressed lane, so a stuck lane blocks the whole input stream.
  assign in_ready = !out_valid[in_sel] | out_ready[in_sel];

  always_comb begin
    load = '0;
    if (in_valid && in_ready) load[in_sel] = 1'b1;
  end

  for (genvar i = 0; i < NLANES; i++) begin : g_lane
    demux_lane #(.W(W)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .load     (load[i]),
      .in_data  (in_data),
      .out_ready(out_ready[i]),
      .out_valid(out_valid[i]),
      .out_data (out_data[i*W +: W])
    );
  end

  assign busy = |out_valid;
endmodule

// File: doc/demux16_dispatch.md
DEMUX16_DISPATCH -- requirements
Module: demux16_dispatch

Interface
REQ-001 Parameter W, default 1, SHALL set the data width of the input word and of each output lane.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 in_valid  input  1  SHALL indicate that the input word is offered.
REQ-005 in_ready  output  1  SHALL indicate that the block accepts the offered word this cycle.
REQ-006 in_sel  input  4  SHALL give the destination lane (0-15) of the offered word.
REQ-007 in_data  input  W  SHALL carry the offered word.
REQ-008 out_valid  output  16  SHALL indicate, per lane, that lane i holds a word.
REQ-009 out_ready  input  16  SHALL indicate, per lane, that the consumer takes lane i's word this cycle.
REQ-010 out_data  output  16*W  SHALL carry lane i's word at bits [i*W +: W].
REQ-011 busy  output  1  SHALL be the OR of all out_valid bits.

Function
REQ-012 The input transfer SHALL occur in a cycle where in_valid and in_ready are both 1.
REQ-013 Each lane SHALL hold one registered entry, consisting of a valid flag and a W-bit data register.
REQ-014 in_ready SHALL equal !out_valid[in_sel] | out_ready[in_sel]; this is combinational from in_sel and out_ready.
REQ-015 in_ready SHALL be independent of in_valid.
REQ-016 On an input transfer, lane in_sel SHALL load in_data, and its out_valid SHALL be 1 in the next cycle.
REQ-017 Latency from input transfer to out_valid SHALL be exactly 1 cycle; there is no combinational in-to-out data path.
REQ-018 A lane's output transfer SHALL occur when out_valid[i] and out_ready[i] are both 1; the lane then clears its valid flag in the next cycle unless it is reloaded.
REQ-019 Simultaneous output transfer and input transfer to the same lane SHALL reload that lane, keeping out_valid[i]=1 with the new data, so one word per cycle is sustained per lane.
REQ-020 Lanes other than in_sel SHALL be unaffected by an input transfer; any number of lanes may drain in the same cycle.
REQ-021 While out_valid[i]=1 and out_ready[i]=0, out_data for lane i SHALL be held stable.
REQ-022 When in_valid=0, no lane SHALL load, regardless of in_sel.
REQ-023 When lane in_sel is full and out_ready[in_sel]=0, in_ready SHALL be 0 and the word SHALL stay with the producer; words to other lanes are blocked behind it in order, with no reordering.
REQ-024 out_data of an empty lane SHALL hold its last value; consumers SHALL ignore it.

Reset
REQ-025 While rst=1, all out_valid bits SHALL be 0 and busy SHALL be 0 immediately, without waiting for a clock edge.
REQ-026 Data registers SHALL reset to 0.
REQ-027 A reset asserted mid-operation SHALL discard all held words.
REQ-028 The first input transfer SHALL be possible in the first rising edge after rst deasserts.

Structure
REQ-029 Constants NLANES=16 and SELW=4 SHALL live in the shared package/include used by the lib muxes.
REQ-030 One sub-module, demux_lane, parameterized by W, SHALL implement the single-entry valid/data register for one lane; it is instantiated 16 times.
REQ-031 A combinational selector SHALL pick out_valid[in_sel]/out_ready[in_sel] for in_ready; it may reuse mux16x1 with W=1.

Verification
REQ-032 Reset case: with rst pulsed mid-stream while lane 3 is full, out_valid SHALL be 16'h0000 asynchronously and after release.
REQ-033 Basic routing: with W=8, sel=5, data=8'hA5, all out_ready=1, out_valid SHALL be 16'h0020 one cycle later and out_data[47:40]=8'hA5.
REQ-034 Backpressure: fill lane 2 with out_ready[2]=0, then offer sel=2 → in_ready=0, lane 2 data unchanged; offer sel=7 → still blocked (in order); raise out_ready[2] → in_ready=1.
REQ-035 Full-rate throughput: 16 back-to-back words to lane 15 with out_ready[15]=1 SHALL give 16 consecutive output transfers with no bubble and data in order.
REQ-036 Sweep case: sel sweeping 0..15 with all out_ready=0 SHALL end with out_valid=16'hFFFF and each lane holding its word; then in_ready=0 for every sel.
REQ-037 Random case: random in_valid/in_sel/out_ready against a scoreboard of per-lane queues SHALL show no lost, duplicated, or reordered words.
